// File: rtl/divu_seq_param_if.sv
// divu_seq_param_if: request/response handshake bundle for the iterative divider
interface divu_seq_param_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    modport master (
        output req_valid, is_signed, dividend, divisor, rsp_ready,
        input  req_ready, rsp_valid, quotient, remainder, busy
    );
    modport slave (
        input  req_valid, is_signed, dividend, divisor, rsp_ready,
        output req_ready, rsp_valid, quotient, remainder, busy
    );
endinterface

// File: rtl/divu_seq_param.sv
// divu_seq_param: multi-cycle restoring divider, ITERS_PER_CYCLE steps per clock, RISC-V DIV/DIVU/REM/REMU results.
// Optional macro DIVU_SEQ_FASTPATH_EN: divisor 0 or unsigned divisor 1 completes one edge after accept.
module divu_seq_param #(
    parameter int WIDTH           = 32,
    parameter int ITERS_PER_CYCLE = 1
) (
    input logic              i_clk,
    input logic              i_rst_n,
    divu_seq_param_if.slave  bus
);
    localparam int N  = WIDTH / ITERS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd, dsr, rem, quo;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, div_zero;
    logic             dd_neg, ds_neg;
    logic [WIDTH-1:0] dd_mag, ds_mag;
    logic [WIDTH-1:0] rem_n, dvd_n, quo_n, q_fin, r_fin;
    logic [WIDTH:0]   trial;
    logic             take, last;
`ifdef DIVU_SEQ_FASTPATH_EN
    logic             fast;
    assign last = fast || cnt == CW'(1);
`else
    assign last = cnt == CW'(1);
`endif

    // Operand magnitudes and signs as seen at the accept edge
    always_comb begin
        dd_neg = bus.is_signed && bus.dividend[WIDTH-1];
        ds_neg = bus.is_signed && bus.divisor[WIDTH-1];
        dd_mag = dd_neg ? -bus.dividend : bus.dividend;
        ds_mag = ds_neg ? -bus.divisor : bus.divisor;
    end

    // Unrolled restoring steps; the trial remainder is one bit wider so the compare never truncates
    always_comb begin
        rem_n = rem;
        dvd_n = dvd;
        quo_n = quo;
        trial = '0;
        take  = 1'b0;
        for (int k = 0; k < ITERS_PER_CYCLE; k++) begin
            trial = {rem_n, dvd_n[WIDTH-1]};
            take  = trial >= {1'b0, dsr};
            trial = take ? trial - {1'b0, dsr} : trial;
            rem_n = trial[WIDTH-1:0];
            dvd_n = dvd_n << 1;
            quo_n = {quo_n[WIDTH-2:0], take};
        end
`ifdef DIVU_SEQ_FASTPATH_EN
        quo_n = fast ? (div_zero ? '1 : dvd) : quo_n;
        rem_n = fast ? (div_zero ? dvd : '0) : rem_n;
`endif
        q_fin = (q_neg && !div_zero) ? -quo_n : quo_n;
        r_fin = r_neg ? -rem_n : rem_n;
    end

    // Control FSM with registered handshake flags and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            dvd           <= '0;
            dsr           <= '0;
            rem           <= '0;
            quo           <= '0;
            cnt           <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            div_zero      <= 1'b0;
`ifdef DIVU_SEQ_FASTPATH_EN
            fast          <= 1'b0;
`endif
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    dvd           <= dd_mag;
                    dsr           <= ds_mag;
                    q_neg         <= dd_neg ^ ds_neg;
                    r_neg         <= dd_neg;
                    div_zero      <= bus.divisor == '0;
`ifdef DIVU_SEQ_FASTPATH_EN
                    fast          <= bus.divisor == '0 || (bus.divisor == WIDTH'(1) && !bus.is_signed);
`endif
                    rem           <= '0;
                    quo           <= '0;
                    cnt           <= CW'(N);
                    state         <= CALC;
                    bus.req_ready <= 1'b0;
                    bus.busy      <= 1'b1;
                end
                CALC: begin
                    rem <= rem_n;
                    dvd <= dvd_n;
                    quo <= quo_n;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        bus.quotient  <= q_fin;
                        bus.remainder <= r_fin;
                        bus.rsp_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
